ibex_data_bus_responder: RTL

- Memory-side responder for the core's data bus (req/gnt/rvalid protocol). It is the far end of the LSU request path, whose `data_req_o` is gated by the PMP error.
- Accepts word-aligned loads and stores into a byte-enabled memory model. Grants after a configurable stall and returns in-order responses a fixed number of cycles after grant.
- Flags out-of-range or misaligned accesses with `data_err_o`, which feeds the core's `lsu_load_err`/`lsu_store_err` path.
- Used in simulation/FPGA tops and as the verification partner for the LSU.

---
 rtl/ibex_dbus_resp_pkg.sv | 27 ++
 rtl/ibex_dbus_resp_mem.sv | 28 ++
 rtl/ibex_data_bus_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ibex_dbus_resp_pkg.sv
// Shared types and constants for the data-bus responder and its memory model.
package ibex_dbus_resp_pkg;

  localparam int unsigned DbusWordBytes = 4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    GntIdle,
    GntStall,
    GntGrant
  } gnt_state_e;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < DbusWordBytes; i++) begin
      if (be[i]) mask[8*i +: 8] = 8'hFF;
    end
    return mask;
  endfunction

endpackage

// File: rtl/ibex_dbus_resp_mem.sv
// Single-port byte-enabled word memory: synchronous write, combinational read.
module ibex_dbus_resp_mem
  import ibex_dbus_resp_pkg::*;
#(
  parameter int unsigned MemSizeWords = 1024,
  parameter int unsigned IdxW         = $clog2(MemSizeWords)
) (
  input  logic            clk_i,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [IdxW-1:0] idx,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [31:0] mem [MemSizeWords];

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int unsigned i = 0; i < DbusWordBytes; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ibex_data_bus_responder.sv
// Memory-side responder for the core data bus: stalled grants, decode,
// fixed-latency in-order responses and error accounting.
module ibex_data_bus_responder
  import ibex_dbus_resp_pkg::*;
#(
  parameter int unsigned MemSizeWords   = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned GntLatency     = 0,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        busy_o,
  output logic [15:0] err_count_o
);

  localparam int unsigned IdxW    = $clog2(MemSizeWords);
  localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(MemSizeWords * DbusWordBytes);
  localparam logic [3:0]  GntLat  = 4'(GntLatency);
  localparam logic [2:0]  MaxOut  = 3'(MaxOutstanding);

  gnt_state_e  state_q, state_d;
  logic [3:0]  stall_q, stall_d;
  logic [2:0]  outst_q, outst_d;
  logic        busy_q;
  logic [15:0] err_count_q;
  logic        room;
  logic        gnt;

  assign room = outst_q < MaxOut;

  // Counter saturates at GntLatency so a stall caused only by the
  // outstanding limit still grants as soon as a slot frees up.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    gnt     = 1'b0;
    unique case (state_q)
      GntIdle, GntGrant: begin
        if (!data_req_i) begin
          state_d = GntIdle;
          stall_d = '0;
        end else if (GntLat == '0 && room) begin
          gnt     = 1'b1;
          state_d = GntGrant;
          stall_d = '0;
        end else begin
          state_d = GntStall;
          stall_d = (GntLat == '0) ? 4'd0 : 4'd1;
        end
      end
      GntStall: begin
        if (!data_req_i) begin
          state_d = GntIdle;
          stall_d = '0;
        end else if (stall_q == GntLat && room) begin
          gnt     = 1'b1;
          state_d = GntGrant;
          stall_d = '0;
        end else if (stall_q != GntLat) begin
          stall_d = stall_q + 4'd1;
        end
      end
      default: state_d = GntIdle;
    endcase
  end

  assign data_gnt_o = gnt;

  logic [32:0]     addr_ext;
  logic            dec_err;
  logic [31:0]     offset;
  logic [IdxW-1:0] idx;
  logic [31:0]     mem_rdata;
  logic            mem_we;
  dbus_resp_t      entry;

  assign addr_ext = {1'b0, data_addr_i};
  assign dec_err  = (data_addr_i < BaseAddr) || (addr_ext >= EndAddr) ||
                    (data_addr_i[1:0] != 2'b00) || (data_we_i && data_be_i == '0);
  assign offset   = data_addr_i - BaseAddr;
  assign idx      = IdxW'(offset >> 2);
  assign mem_we   = gnt && data_we_i && !dec_err;

  ibex_dbus_resp_mem #(
    .MemSizeWords(MemSizeWords),
    .IdxW        (IdxW)
  ) u_mem (
    .clk_i(clk_i),
    .we   (mem_we),
    .be   (data_be_i),
    .idx  (idx),
    .wdata(data_wdata_i),
    .rdata(mem_rdata)
  );

  always_comb begin
    entry       = '0;
    entry.valid = gnt;
    entry.err   = gnt && dec_err;
    if (gnt && !data_we_i && !dec_err) entry.rdata = mem_rdata & be_mask(data_be_i);
  end

  dbus_resp_t pipe_q [RespLatency];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RespLatency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= entry;
      for (int unsigned i = 1; i < RespLatency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign data_rvalid_o = pipe_q[RespLatency-1].valid;
  assign data_err_o    = pipe_q[RespLatency-1].err;
  assign data_rdata_o  = pipe_q[RespLatency-1].rdata;

  assign outst_d = outst_q + {2'b00, gnt} - {2'b00, data_rvalid_o};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= GntIdle;
      stall_q     <= '0;
      outst_q     <= '0;
      busy_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      outst_q <= outst_d;
      busy_q  <= outst_d != '0;
      if (data_rvalid_o && data_err_o && err_count_q != '1) err_count_q <= err_count_q + 16'd1;
    end
  end

  assign busy_o      = busy_q;
  assign err_count_o = err_count_q;

`ifndef SYNTHESIS
  req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_req_i && !data_gnt_o |=> !data_req_i ||
      $stable({data_addr_i, data_we_i, data_be_i, data_wdata_i}));

  rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_o |-> outst_q != '0);

  if (MemSizeWords < 4 || (MemSizeWords & (MemSizeWords - 1)) != 0) begin : g_bad_size
    $error("MemSizeWords must be a power of two >= 4");
  end
  if ((BaseAddr & 32'(MemSizeWords * DbusWordBytes - 1)) != '0) begin : g_bad_base
    $error("BaseAddr must be aligned to the memory size");
  end
  if (GntLatency > 15) begin : g_bad_gnt
    $error("GntLatency must be 0..15");
  end
  if (RespLatency < 1 || RespLatency > 4) begin : g_bad_resp
    $error("RespLatency must be 1..4");
  end
  if (MaxOutstanding < 1 || MaxOutstanding > 4) begin : g_bad_out
    $error("MaxOutstanding must be 1..4");
  end
`endif

endmodule
